// File: rtl/lsu_rmw.sv
// Load/store unit: byte/half stores become a read then a merged full-word write;
// loads are lane-extracted and extended. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned,
  output logic [ADDR_W-1:0] misaligned_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MERGE_WR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;

  logic              is_byte, is_half, is_word, addr_bad, in_idle;
  logic              do_load, do_wst, do_sst, trap;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        rd_b;
  logic [15:0]       rd_h;
  logic [31:0]       ld_ext, merged;

  assign is_byte   = (req_size == 2'b00);
  assign is_half   = (req_size == 2'b01);
  assign is_word   = req_size[1];
  assign in_idle   = (state_q == IDLE);
  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign addr_bad = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
  // Without trapping, low address bits are simply ignored (forced alignment).
  assign addr_bad = 1'b0;
`endif

  assign do_load = in_idle && req_valid && !addr_bad && !req_write;
  assign do_wst  = in_idle && req_valid && !addr_bad && req_write && is_word;
  assign do_sst  = in_idle && req_valid && !addr_bad && req_write && !is_word;
  assign trap    = in_idle && req_valid && addr_bad;

  always_comb begin
    rd_b = mem_rdata[7:0];
    case (req_addr[1:0])
      2'b01:   rd_b = mem_rdata[15:8];
      2'b10:   rd_b = mem_rdata[23:16];
      2'b11:   rd_b = mem_rdata[31:24];
      default: rd_b = mem_rdata[7:0];
    endcase
    rd_h = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_byte)
      ld_ext = {{24{!req_unsigned && rd_b[7]}}, rd_b};
    else if (is_half)
      ld_ext = {{16{!req_unsigned && rd_h[15]}}, rd_h};
    else
      ld_ext = mem_rdata;
  end

  always_comb begin
    merged = mem_rdata;
    if (is_byte) begin
      case (req_addr[1:0])
        2'b01:   merged[15:8]  = req_wdata[7:0];
        2'b10:   merged[23:16] = req_wdata[7:0];
        2'b11:   merged[31:24] = req_wdata[7:0];
        default: merged[7:0]   = req_wdata[7:0];
      endcase
    end else if (req_addr[1]) begin
      merged[31:16] = req_wdata[15:0];
    end else begin
      merged[15:0] = req_wdata[15:0];
    end
  end

  always_comb begin
    state_d      = IDLE;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    load_valid_d = do_load;
    load_data_d  = do_load ? ld_ext : load_data_q;
    mis_d        = trap;
    mis_addr_d   = trap ? req_addr : mis_addr_q;
    if (do_sst) begin
      state_d     = MERGE_WR;
      hold_addr_d = word_addr;
      hold_data_d = merged;
    end
  end

  // Reset must suppress a pending merge write immediately, not at the next edge.
  assign mem_we    = !rst && (!in_idle || do_wst);
  assign stall     = !rst && do_sst;
  assign mem_addr  = in_idle ? word_addr : hold_addr_q;
  assign mem_wdata = in_idle ? req_wdata : hold_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      mis_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      mis_q        <= mis_d;
      mis_addr_q   <= mis_addr_d;
    end
  end

  assign load_data       = load_data_q;
  assign load_valid      = load_valid_q;
  assign misaligned      = mis_q;
  assign misaligned_addr = mis_addr_q;

endmodule
